// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared fetch-stage constants: FSM encoding, halt word and
//               default instruction-memory geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_I_ADDR_BITS      = 6;
    localparam int c_INSTRUCTION_SIZE = 32;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;

    // An all-zero word is an illegal RISC-V encoding and doubles as "stop".
    localparam logic [c_INSTRUCTION_SIZE-1:0] c_HALT_WORD = '0;

endpackage
`default_nettype wire

// File: rtl/fetch_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_out_buffer
// Description : One-entry valid/ready register slice holding {instruction, pc}.
//               Priority: flush > load > hold > drain.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_out_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic              i_hold,
    input  logic [DATA_W-1:0] i_instruction,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instruction,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instruction;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_instruction <= '0;
            r_pc          <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid       <= 1'b1;
            r_instruction <= i_instruction;
            r_pc          <= i_pc;
        end else if (!i_hold) begin
            // Neither refilled nor stalled: the entry was consumed or is empty.
            r_valid <= 1'b0;
        end
    end

    assign o_valid       = r_valid;
    assign o_instruction = r_instruction;
    assign o_pc          = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch controller owning the PC; presents fetched
//               words to decode. Optional macro FETCH_PERF_COUNTERS_EN adds
//               fetch/stall performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int I_ADDR_BITS      = c_I_ADDR_BITS,
    parameter int INSTRUCTION_SIZE = c_INSTRUCTION_SIZE,
    parameter int RESET_PC         = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic [I_ADDR_BITS-1:0]      imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
    input  logic                        redirect_valid,
    input  logic [I_ADDR_BITS-1:0]      redirect_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTION_SIZE-1:0] out_instruction,
    output logic [I_ADDR_BITS-1:0]      out_pc,
    output logic                        halted,
    output logic                        busy
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                 fetch_count,
    output logic [31:0]                 stall_count
`endif
);

    localparam logic [I_ADDR_BITS-1:0] c_RESET_PC = I_ADDR_BITS'(RESET_PC);
    localparam logic [INSTRUCTION_SIZE-1:0] c_HALT = INSTRUCTION_SIZE'(c_HALT_WORD);

    logic [1:0]             r_state;
    logic [I_ADDR_BITS-1:0] r_pc;

    logic w_in_run;
    logic w_in_halted;
    logic w_restart;
    logic w_fetch;
    logic w_is_halt;
    logic w_load;
    logic w_flush;
    logic w_hold;

    assign w_in_run    = (r_state == c_RUN);
    assign w_in_halted = (r_state == c_HALTED);
    assign w_restart   = start && ((r_state == c_IDLE) || w_in_halted);
    assign w_fetch     = w_in_run && (!out_valid || out_ready) && !redirect_valid;
    assign w_is_halt   = (imem_instruction == c_HALT);
    assign w_load      = w_fetch && !w_is_halt;
    assign w_flush     = (w_in_run && redirect_valid) || (w_in_halted && start);
    assign w_hold      = out_valid && !out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_pc    <= c_RESET_PC;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_pc    <= c_RESET_PC;
                    end
                end
                c_RUN: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_addr;
                    end else if (w_fetch) begin
                        // PC stays on the halt word so imem_addr shows where we stopped.
                        if (w_is_halt) r_state <= c_HALTED;
                        else           r_pc    <= r_pc + 1'b1;
                    end
                end
                c_HALTED: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_pc    <= c_RESET_PC;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    fetch_out_buffer #(
        .DATA_W(INSTRUCTION_SIZE),
        .ADDR_W(I_ADDR_BITS)
    ) u_out_buffer (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_load),
        .i_flush      (w_flush),
        .i_hold       (w_hold),
        .i_instruction(imem_instruction),
        .i_pc         (r_pc),
        .o_valid      (out_valid),
        .o_instruction(out_instruction),
        .o_pc         (out_pc)
    );

    assign imem_addr = r_pc;
    assign halted    = w_in_halted;
    assign busy      = w_in_run;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else if (w_restart) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_load && (r_fetch_count != '1))
                r_fetch_count <= r_fetch_count + 1'b1;
            if (w_in_run && w_hold && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int AW = 6;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_instruction;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instruction;
    logic [AW-1:0] out_pc;
    logic          halted;
    logic          busy;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0]   fetch_count;
    logic [31:0]   stall_count;
`endif

    logic [IW-1:0] mem  [0:63];
    logic [IW-1:0] prog [0:3];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_addr];

    fetch_sequencer #(
        .I_ADDR_BITS(AW),
        .INSTRUCTION_SIZE(IW),
        .RESET_PC(0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .imem_addr       (imem_addr),
        .imem_instruction(imem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .halted          (halted),
        .busy            (busy)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_program;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_instruction !== '0 || out_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b i=%h pc=%0d, expected v=0 i=0 pc=0", out_valid, out_instruction, out_pc);
        end
        n_cmp++;
        if (imem_addr !== 6'd0 || halted !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%0d halted=%b busy=%b, expected 0/0/0", imem_addr, halted, busy);
        end
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_run_to_halt;
        load_program;
        out_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || imem_addr !== 6'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: got busy=%b addr=%0d v=%b, expected 1/0/0", busy, imem_addr, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== AW'(i) || out_instruction !== prog[i]) begin
                n_fail++;
                $display("FAIL stream_word%0d: got v=%b pc=%0d i=%h, expected v=1 pc=%0d i=%h", i, out_valid, out_pc, out_instruction, i, prog[i]);
            end
        end
        tick;
        n_cmp++;
        if (halted !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 6'd4) begin
            n_fail++;
            $display("FAIL halt: got halted=%b busy=%b v=%b addr=%0d, expected 1/0/0/4", halted, busy, out_valid, imem_addr);
        end
`ifdef FETCH_PERF_COUNTERS_EN
        n_cmp++;
        if (fetch_count !== 32'd4) begin
            n_fail++;
            $display("FAIL perf_fetch_count: got %0d, expected 4", fetch_count);
        end
`endif
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
        n_cmp++;
        if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_clear_on_start: got f=%0d s=%0d, expected 0/0", fetch_count, stall_count);
        end
`endif
        tick;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 6'd0 || out_instruction !== 32'h00002083 || imem_addr !== 6'd1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b pc=%0d i=%h addr=%0d, expected 1/0/00002083/1", i, out_valid, out_pc, out_instruction, imem_addr);
            end
        end
        out_ready = 1'b1;
        tick;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 6'd1 || out_instruction !== 32'h08002103) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b pc=%0d i=%h, expected 1/1/08002103", out_valid, out_pc, out_instruction);
        end
        tick;
        tick;
        tick;
        n_cmp++;
        if (halted !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_then_halt: got halted=%b v=%b, expected 1/0", halted, out_valid);
        end
`ifdef FETCH_PERF_COUNTERS_EN
        n_cmp++;
        if (fetch_count !== 32'd4 || stall_count !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_stall_count: got f=%0d s=%0d, expected 4/3", fetch_count, stall_count);
        end
`endif
    endtask

    task automatic test_redirect;
        out_ready = 1'b1;
        redirect_addr = 6'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 6'd2) begin
            n_fail++;
            $display("FAIL redirect_pre: got v=%b pc=%0d, expected 1/2", out_valid, out_pc);
        end
        redirect_valid = 1'b1;
        tick;
        redirect_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || imem_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL redirect_flush: got v=%b addr=%0d, expected 0/0", out_valid, imem_addr);
        end
        tick;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 6'd0 || out_instruction !== 32'h00002083) begin
            n_fail++;
            $display("FAIL redirect_target: got v=%b pc=%0d i=%h, expected 1/0/00002083", out_valid, out_pc, out_instruction);
        end
    endtask

    task automatic test_reset_mid_stall;
        out_ready = 1'b0;
        tick;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || imem_addr !== 6'd0 || busy !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b addr=%0d busy=%b halted=%b, expected 0/0/0/0", out_valid, imem_addr, busy, halted);
        end
        #1;
        reset = 1'b0;
        redirect_addr = 6'd5;
        redirect_valid = 1'b1;
        tick;
        redirect_valid = 1'b0;
        n_cmp++;
        if (imem_addr !== 6'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_redirect: got addr=%0d v=%b busy=%b, expected 0/0/0", imem_addr, out_valid, busy);
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 6'd0 || out_instruction !== 32'h00002083) begin
            n_fail++;
            $display("FAIL restart_after_reset: got v=%b pc=%0d i=%h, expected 1/0/00002083", out_valid, out_pc, out_instruction);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | 32'(i + 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        redirect_addr = 6'd63;
        redirect_valid = 1'b1;
        tick;
        redirect_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || imem_addr !== 6'd63) begin
            n_fail++;
            $display("FAIL wrap_redirect: got v=%b addr=%0d, expected 0/63", out_valid, imem_addr);
        end
        tick;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 6'd63 || out_instruction !== 32'hA5A5_0040) begin
            n_fail++;
            $display("FAIL wrap_pc63: got v=%b pc=%0d i=%h, expected 1/63/a5a50040", out_valid, out_pc, out_instruction);
        end
        tick;
        n_cmp++;
        if (out_pc !== 6'd0 || imem_addr !== 6'd1 || out_instruction !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL wrap_pc0: got pc=%0d addr=%0d i=%h, expected 0/1/a5a50001", out_pc, imem_addr, out_instruction);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++;
        if (out_pc !== 6'd1 || out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_ignores_start: got pc=%0d v=%b busy=%b, expected 1/1/1", out_pc, out_valid, busy);
        end
    endtask

    initial begin
        prog[0] = 32'h00002083;
        prog[1] = 32'h08002103;
        prog[2] = 32'h40208133;
        prog[3] = 32'h00208363;
        reset = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        out_ready = 1'b0;
        load_program;
        #1;

        test_reset;
        test_run_to_halt;
        test_stall;
        test_redirect;
        test_reset_mid_stall;
        test_wrap;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
